// File: rtl/pipe_collision.sv
// rtl/pipe_collision.sv - game-state FSM, scrolling pipes, collision detection and score
// Pipes move right-to-left in RUN; a hit freezes everything and parks the game in DEAD until reset.
module pipe_collision #(
  parameter int         SCREEN_WIDTH  = 640,
  parameter int         SCREEN_HEIGHT = 480,
  parameter int         BIRD_X        = 160,
  parameter int         BIRD_HALF     = 16,
  parameter int         PIPE_WIDTH    = 60,
  parameter int         PIPE_SPACING  = 320,
  parameter int         SCROLL        = 2,
  parameter int         GAP_HALF      = 80,
  parameter int         GAP_Y_MIN     = 112,
  parameter logic [9:0] LFSR_SEED     = 10'h2A5
) (
  input  logic               gameClk,
  input  logic               reset,
  input  logic               start,
  input  logic signed [10:0] y_in,
  output logic               finished,
  output logic [1:0]         state,
  output logic signed [10:0] pipe0_x,
  output logic signed [10:0] pipe1_x,
  output logic signed [10:0] pipe0_gap,
  output logic signed [10:0] pipe1_gap,
  output logic [9:0]         score
);

  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DEAD = 2'b10} state_t;

  localparam logic signed [11:0] BIRD_LEFT  = 12'(BIRD_X - BIRD_HALF);
  localparam logic signed [11:0] BIRD_RIGHT = 12'(BIRD_X + BIRD_HALF);
  localparam logic signed [11:0] BIRD_XC    = 12'(BIRD_X);
  localparam logic signed [11:0] HALF       = 12'(BIRD_HALF);
  localparam logic signed [11:0] PW         = 12'(PIPE_WIDTH);
  localparam logic signed [11:0] NEG_PW     = 12'(-PIPE_WIDTH);
  localparam logic signed [11:0] STEP       = 12'(SCROLL);
  localparam logic signed [11:0] WRAP       = 12'(2 * PIPE_SPACING);
  localparam logic signed [11:0] GH         = 12'(GAP_HALF);
  localparam logic signed [11:0] GMIN       = 12'(GAP_Y_MIN);

  state_t             state_q, state_d;
  logic               finished_q, finished_d;
  logic signed [10:0] pipe0_x_q, pipe0_x_d, pipe1_x_q, pipe1_x_d;
  logic signed [10:0] pipe0_gap_q, pipe0_gap_d, pipe1_gap_q, pipe1_gap_d;
  logic [9:0]         score_q, score_d;
  logic [9:0]         lfsr_q, lfsr_d;

  logic signed [11:0] y_w, x0, x1, g0, g1, nx0, nx1, new_gap;
  logic               hit, wrap0, wrap1, cross0, cross1;
  logic [1:0]         inc;
  logic [10:0]        score_sum;

  function automatic logic pipe_hit(input logic signed [11:0] x,
                                    input logic signed [11:0] gap,
                                    input logic signed [11:0] y);
    return (BIRD_RIGHT > x) && (BIRD_LEFT < x + PW) &&
           ((y - HALF < gap - GH) || (y + HALF > gap + GH));
  endfunction

  always_comb begin
    y_w     = 12'(y_in);
    x0      = 12'(pipe0_x_q);
    x1      = 12'(pipe1_x_q);
    g0      = 12'(pipe0_gap_q);
    g1      = 12'(pipe1_gap_q);
    nx0     = x0 - STEP;
    nx1     = x1 - STEP;
    wrap0   = nx0 <= NEG_PW;
    wrap1   = nx1 <= NEG_PW;
    cross0  = (x0 + PW >= BIRD_XC) && (nx0 + PW < BIRD_XC);
    cross1  = (x1 + PW >= BIRD_XC) && (nx1 + PW < BIRD_XC);
    new_gap = GMIN + $signed({4'b0000, lfsr_q[7:0]});
    hit     = (state_q == RUN) &&
              ((y_w <= HALF) || pipe_hit(x0, g0, y_w) || pipe_hit(x1, g1, y_w));
    inc       = {1'b0, cross0} + {1'b0, cross1};
    score_sum = {1'b0, score_q} + {9'd0, inc};
    // Free-running in every state so the moment start is pressed seeds the gaps.
    lfsr_d      = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
    state_d     = state_q;
    pipe0_x_d   = pipe0_x_q;
    pipe1_x_d   = pipe1_x_q;
    pipe0_gap_d = pipe0_gap_q;
    pipe1_gap_d = pipe1_gap_q;
    score_d     = score_q;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        if (hit) begin
          state_d = DEAD;
        end else begin
          pipe0_x_d = wrap0 ? 11'(nx0 + WRAP) : 11'(nx0);
          pipe1_x_d = wrap1 ? 11'(nx1 + WRAP) : 11'(nx1);
          if (wrap0) pipe0_gap_d = 11'(new_gap);
          if (wrap1) pipe1_gap_d = 11'(new_gap);
          score_d = (score_sum > 11'd999) ? 10'd999 : score_sum[9:0];
        end
      end
      default: ;
    endcase
    finished_d = (state_d != RUN);
  end

  always_ff @(posedge gameClk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      finished_q  <= 1'b1;
      pipe0_x_q   <= 11'(SCREEN_WIDTH);
      pipe1_x_q   <= 11'(SCREEN_WIDTH + PIPE_SPACING);
      pipe0_gap_q <= 11'(SCREEN_HEIGHT / 2);
      pipe1_gap_q <= 11'(SCREEN_HEIGHT / 2);
      score_q     <= 10'd0;
      lfsr_q      <= LFSR_SEED;
    end else begin
      state_q     <= state_d;
      finished_q  <= finished_d;
      pipe0_x_q   <= pipe0_x_d;
      pipe1_x_q   <= pipe1_x_d;
      pipe0_gap_q <= pipe0_gap_d;
      pipe1_gap_q <= pipe1_gap_d;
      score_q     <= score_d;
      lfsr_q      <= lfsr_d;
    end
  end

  assign finished  = finished_q;
  assign state     = state_q;
  assign pipe0_x   = pipe0_x_q;
  assign pipe1_x   = pipe1_x_q;
  assign pipe0_gap = pipe0_gap_q;
  assign pipe1_gap = pipe1_gap_q;
  assign score     = score_q;

endmodule

// File: tb/tb_pipe_collision.sv
// tb/tb_pipe_collision.sv - self-checking bench for pipe_collision
// Reference model tracks game rules in plain integers and is compared every cycle.
module tb_pipe_collision;

  localparam int BIRD_X = 160, BIRD_HALF = 16, PIPE_WIDTH = 60, PIPE_SPACING = 320;
  localparam int SCROLL = 2, GAP_HALF = 80, GAP_Y_MIN = 112;

  logic               gameClk = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic signed [10:0] y_in = 11'sd240;
  logic               finished;
  logic [1:0]         state;
  logic signed [10:0] pipe0_x, pipe1_x, pipe0_gap, pipe1_gap;
  logic [9:0]         score;

  int vectors = 0;
  int miscompares = 0;
  int m_state, m_p0x, m_p1x, m_g0, m_g1, m_score, m_lfsr;

  pipe_collision dut (
    .gameClk(gameClk), .reset(reset), .start(start), .y_in(y_in),
    .finished(finished), .state(state),
    .pipe0_x(pipe0_x), .pipe1_x(pipe1_x),
    .pipe0_gap(pipe0_gap), .pipe1_gap(pipe1_gap), .score(score)
  );

  always #5 gameClk = ~gameClk;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lfsr_next(input int v);
    int fb;
    fb = ((v >> 9) ^ (v >> 6)) & 1;
    return ((v << 1) | fb) & 'h3FF;
  endfunction

  function automatic bit blocked(input int x, input int g, input int y);
    bit horiz, vert;
    horiz = (BIRD_X + BIRD_HALF > x) && (BIRD_X - BIRD_HALF < x + PIPE_WIDTH);
    vert  = (y - BIRD_HALF < g - GAP_HALF) || (y + BIRD_HALF > g + GAP_HALF);
    return horiz && vert;
  endfunction

  task automatic model_reset();
    m_state = 0; m_p0x = 640; m_p1x = 960; m_g0 = 240; m_g1 = 240;
    m_score = 0; m_lfsr = 'h2A5;
  endtask

  task automatic model_step();
    int y, n0, n1, gap_new;
    y = y_in;
    gap_new = GAP_Y_MIN + (m_lfsr & 'hFF);
    if (m_state == 0) begin
      if (start) m_state = 1;
    end else if (m_state == 1) begin
      if (y <= BIRD_HALF || blocked(m_p0x, m_g0, y) || blocked(m_p1x, m_g1, y)) begin
        m_state = 2;
      end else begin
        n0 = m_p0x - SCROLL;
        n1 = m_p1x - SCROLL;
        if (m_p0x + PIPE_WIDTH >= BIRD_X && n0 + PIPE_WIDTH < BIRD_X) m_score++;
        if (m_p1x + PIPE_WIDTH >= BIRD_X && n1 + PIPE_WIDTH < BIRD_X) m_score++;
        if (m_score > 999) m_score = 999;
        if (n0 <= -PIPE_WIDTH) begin n0 += 2 * PIPE_SPACING; m_g0 = gap_new; end
        if (n1 <= -PIPE_WIDTH) begin n1 += 2 * PIPE_SPACING; m_g1 = gap_new; end
        m_p0x = n0;
        m_p1x = n1;
      end
    end
    m_lfsr = lfsr_next(m_lfsr);
  endtask

  task automatic compare_all();
    check("state", int'(state), m_state);
    check("finished", int'(finished), (m_state != 1) ? 1 : 0);
    check("pipe0_x", int'(pipe0_x), m_p0x);
    check("pipe1_x", int'(pipe1_x), m_p1x);
    check("pipe0_gap", int'(pipe0_gap), m_g0);
    check("pipe1_gap", int'(pipe1_gap), m_g1);
    check("score", int'(score), m_score);
  endtask

  task automatic tick();
    @(posedge gameClk);
    if (reset) model_reset(); else model_step();
    @(negedge gameClk);
    compare_all();
  endtask

  task automatic mid_reset();
    #2 reset = 1'b1;
    model_reset();
    #1 compare_all();
    #1 reset = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge gameClk);
    reset = 1'b0;
    compare_all();
    repeat (5) tick();
    pulse_start();
    repeat (50) tick();

    // reset in the middle of play takes effect without a clock
    mid_reset();
    check("t1_state", int'(state), 0);
    check("t1_finished", int'(finished), 1);
    check("t1_p0x", int'(pipe0_x), 640);
    check("t1_p1x", int'(pipe1_x), 960);
    check("t1_gap0", int'(pipe0_gap), 240);
    check("t1_gap1", int'(pipe1_gap), 240);
    check("t1_score", int'(score), 0);

    // clean flight through the first gap, then respawn
    y_in = 11'sd240;
    pulse_start();
    check("t2_finished", int'(finished), 0);
    repeat (271) tick();
    check("t2_p0x_98", int'(pipe0_x), 98);
    check("t2_score_1", int'(score), 1);
    check("t2_alive", int'(state), 1);
    repeat (79) tick();
    check("t2_p0x_580", int'(pipe0_x), 580);
    check("t2_gap_range", (pipe0_gap >= 11'sd112 && pipe0_gap <= 11'sd367) ? 1 : 0, 1);

    // low bird strikes pipe0's lower section
    mid_reset();
    repeat (3) tick();
    y_in = 11'sd100;
    pulse_start();
    repeat (233) tick();
    check("t3_p0x_174", int'(pipe0_x), 174);
    check("t3_still_run", int'(state), 1);
    tick();
    check("t3_dead", int'(state), 2);
    check("t3_finished", int'(finished), 1);
    check("t3_frozen_x", int'(pipe0_x), 174);
    check("t3_score", int'(score), 0);

    // DEAD ignores everything but reset
    repeat (100) begin
      start = 1'($urandom_range(0, 1));
      y_in  = 11'($urandom_range(0, 500));
      tick();
    end
    check("t5_dead", int'(state), 2);
    check("t5_p0x", int'(pipe0_x), 174);
    check("t5_score", int'(score), 0);
    start = 1'b0;
    mid_reset();
    check("t5_idle", int'(state), 0);

    // floor boundary
    y_in = 11'sd17;
    pulse_start();
    repeat (10) tick();
    check("t4_y17_run", int'(state), 1);
    y_in = 11'sd16;
    tick();
    check("t4_y16_dead", int'(state), 2);
    check("t4_finished", int'(finished), 1);

    // score saturation
    mid_reset();
    y_in = 11'sd240;
    pulse_start();
    repeat (270) tick();
    check("t6_p0x_100", int'(pipe0_x), 100);
    force dut.score_q = 10'd999;
    m_score = 999;
    #1 release dut.score_q;
    tick();
    check("t6_p0x_98", int'(pipe0_x), 98);
    check("t6_score_sat", int'(score), 999);

    // hit on the same tick the pipe would have scored
    mid_reset();
    y_in = 11'sd240;
    pulse_start();
    repeat (270) tick();
    y_in = 11'sd100;
    tick();
    check("t6_hit_dead", int'(state), 2);
    check("t6_hit_x", int'(pipe0_x), 100);
    check("t6_hit_score", int'(score), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_collision.md
Name: pipe_collision

Overview:
- Consumer of bird_movement's position and producer of its `finished` freeze input.
- Owns the game-state FSM (IDLE/RUN/DEAD), scrolls two pipes right-to-left, and randomises gap heights with an LFSR.
- Detects bird/pipe and bird/floor collisions and keeps the score.
- Pipe outputs feed the VGA renderer; score feeds the 7-segment driver.
- Coordinates: y is the bird centre, y-up, floor at y=0; x is screen pixels.

Parameters:
- SCREEN_WIDTH, 640, horizontal pixels; pipe spawn x.
- SCREEN_HEIGHT, 480, vertical pixels.
- BIRD_X, 160, fixed bird centre x.
- BIRD_HALF, 16, bird half-size; equals bird_height in constants.v.
- PIPE_WIDTH, 60, pipe width in px; pipe x is its left edge.
- PIPE_SPACING, 320, x distance between pipe0 and pipe1.
- SCROLL, 2, px moved per RUN tick.
- GAP_HALF, 80, half-height of the opening.
- GAP_Y_MIN, 112, minimum gap centre; gap = GAP_Y_MIN + lfsr[7:0].
- LFSR_SEED, 10'h2A5, LFSR reset value; must be nonzero.

Ports:
- gameClk  in  1  game tick clock.
- reset  in  1  asynchronous, active-high.
- start  in  1  flap button, level; starts play from IDLE.
- y_in  in  11 signed  bird centre y.
- finished  out  1  high in IDLE and DEAD; freezes bird.
- state  out  2  00 IDLE, 01 RUN, 10 DEAD.
- pipe0_x  out  11 signed  left edge of pipe 0.
- pipe1_x  out  11 signed  left edge of pipe 1.
- pipe0_gap  out  11 signed  gap centre of pipe 0.
- pipe1_gap  out  11 signed  gap centre of pipe 1.
- score  out  10  pipes passed, saturates at 999.

Behaviour:
- Reset (async, all registers):
  - state=IDLE, finished=1, pipe0_x=SCREEN_WIDTH, pipe1_x=SCREEN_WIDTH+PIPE_SPACING.
  - pipe0_gap=pipe1_gap=240, score=0, lfsr=LFSR_SEED.
- LFSR: 10-bit Fibonacci, taps 10 and 7. It advances every gameClk edge in every state, so start timing randomises gaps.
- FSM:
  - IDLE -> RUN on start=1.
  - RUN -> DEAD on hit.
  - DEAD is sticky until reset; start is ignored in DEAD.
- finished is registered: finished = (next_state != RUN). It drops on the same edge state becomes RUN.
- hit is combinational from current registers and y_in, evaluated only in RUN. Any one condition is a hit:
  - Floor: y_in <= BIRD_HALF.
  - Pipe i, both terms true:
    - horizontal overlap: BIRD_X+BIRD_HALF > pipe_i_x and BIRD_X-BIRD_HALF < pipe_i_x+PIPE_WIDTH;
    - vertical: y_in-BIRD_HALF < gap_i-GAP_HALF or y_in+BIRD_HALF > gap_i+GAP_HALF.
- RUN tick without hit, per pipe: nx = x - SCROLL.
  - If nx <= -PIPE_WIDTH: x <= nx + 2*PIPE_SPACING and gap <= GAP_Y_MIN + lfsr[7:0]. Same-cycle lfsr value; pipe0 uses it if both respawn.
  - Else x <= nx.
- Score: +1 for each pipe where x+PIPE_WIDTH >= BIRD_X and nx+PIPE_WIDTH < BIRD_X. Add both if both cross in one tick; saturate at 999.
- RUN tick with hit: state <= DEAD; pipes, gaps and score hold. Collision beats a same-tick score increment.
- IDLE and DEAD: pipes, gaps and score hold.
- Arithmetic: all comparisons signed, 12-bit intermediates, no wrap. Gap range with defaults is [112,367], which keeps the opening within 32..447.
- Latency: hit at edge N means state=DEAD and finished=1 after edge N. The frozen x is the value that produced the hit.

Test Plan:
1. Assert reset mid-run, deassert -> finished=1, state=0, pipe0_x=640, pipe1_x=960, gaps=240, score=0 immediately, without waiting for a clock.
2. Pulse start, hold y_in=240 -> finished=0 next edge. After 271 RUN ticks, pipe0_x=98 and score=1 with no death. After 350 ticks, pipe0_x=580 and pipe0_gap is in [112,367].
3. Pulse start, hold y_in=100 -> pipe0_x reaches 174 after 233 ticks. The next edge gives state=DEAD, finished=1, pipe0_x frozen at 174, score=0.
4. In RUN, drive y_in=16 -> DEAD and finished=1 after one edge. With y_in=17 and no pipe overlap, stay in RUN.
5. In DEAD, toggle start and y_in for 100 ticks -> state, pipes and score unchanged. Only reset returns to IDLE.
6. Preload score=999 by force, then pass a pipe at y_in=240 -> score stays 999. Separately, arrange a pipe whose right-edge crossing coincides with a hit -> DEAD with score unchanged.
